// File: rtl/imem_loader.sv
// UART boot loader: receives a big-endian word count followed by that many
// big-endian words and writes them into instruction memory from address 0.
module imem_loader #(
    parameter int MEM_BYTES      = 1024,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    input  logic [31:0] cpu_pc_i,
    output logic [31:0] imem_addr_o,
    output logic        imem_we_o,
    output logic [31:0] imem_wdata_o,
    output logic        cpu_stall_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        error_o,
    output logic [31:0] words_loaded_o
);

    localparam int          MAX_WORDS = MEM_BYTES / 4;
    localparam int          TW        = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [31:0] LAST_PTR  = 32'(MEM_BYTES - 4);
    localparam logic [31:0] MAX_LEN   = 32'(MAX_WORDS);
    localparam logic [TW-1:0] TO_LIMIT = TW'(TIMEOUT_CYCLES);

    typedef enum logic [2:0] {IDLE, HDR, DATA, WRITE, DONE, ERR} state_t;

    state_t        state_q, state_d;
    logic [31:0]   len_q, len_d;
    logic [31:0]   buf_q, buf_d;
    logic [1:0]    bcnt_q, bcnt_d;
    logic [31:0]   ptr_q, ptr_d;
    logic [31:0]   words_q, words_d;
    logic [TW-1:0] to_q, to_d;

    logic [31:0]   hdr_word, data_word, words_inc;
    logic [TW-1:0] to_inc;
    logic          session;

    assign hdr_word  = {len_q[23:0], rx_data_i};
    assign data_word = {buf_q[23:0], rx_data_i};
    assign words_inc = words_q + 32'd1;
    assign to_inc    = to_q + 1'b1;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        buf_d   = buf_q;
        bcnt_d  = bcnt_q;
        ptr_d   = ptr_q;
        words_d = words_q;
        to_d    = to_q;
        case (state_q)
            IDLE, DONE, ERR: begin
                if (start_i) begin
                    state_d = HDR;
                    len_d   = '0;
                    buf_d   = '0;
                    bcnt_d  = '0;
                    ptr_d   = '0;
                    words_d = '0;
                    to_d    = '0;
                end
            end
            HDR: begin
                if (rx_valid_i) begin
                    len_d  = hdr_word;
                    bcnt_d = bcnt_q + 2'd1;
                    to_d   = '0;
                    if (bcnt_q == 2'd3) begin
                        if (hdr_word == 32'd0)         state_d = DONE;
                        else if (hdr_word > MAX_LEN)   state_d = ERR;
                        else                           state_d = DATA;
                    end
                end else if (to_inc == TO_LIMIT) begin
                    state_d = ERR;
                    to_d    = to_inc;
                end else begin
                    to_d = to_inc;
                end
            end
            DATA: begin
                if (rx_valid_i) begin
                    buf_d  = data_word;
                    bcnt_d = bcnt_q + 2'd1;
                    to_d   = '0;
                    if (bcnt_q == 2'd3) state_d = WRITE;
                end else if (to_inc == TO_LIMIT) begin
                    state_d = ERR;
                    to_d    = to_inc;
                end else begin
                    to_d = to_inc;
                end
            end
            WRITE: begin
                words_d = words_inc;
                to_d    = '0;
                // Pointer parks on the last word so it never leaves the memory.
                if (ptr_q != LAST_PTR) ptr_d = ptr_q + 32'd4;
                if (words_inc == len_q) begin
                    state_d = DONE;
                end else begin
                    state_d = DATA;
                    // A byte landing during the write starts the next word.
                    if (rx_valid_i) begin
                        buf_d  = {24'd0, rx_data_i};
                        bcnt_d = 2'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            len_q   <= '0;
            buf_q   <= '0;
            bcnt_q  <= '0;
            ptr_q   <= '0;
            words_q <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            buf_q   <= buf_d;
            bcnt_q  <= bcnt_d;
            ptr_q   <= ptr_d;
            words_q <= words_d;
            to_q    <= to_d;
        end
    end

    assign session        = (state_q == HDR) || (state_q == DATA) || (state_q == WRITE);
    assign imem_addr_o    = session ? ptr_q : cpu_pc_i;
    assign imem_we_o      = (state_q == WRITE);
    assign imem_wdata_o   = (state_q == WRITE) ? buf_q : 32'd0;
    assign cpu_stall_o    = session;
    assign busy_o         = session;
    assign done_o         = (state_q == DONE);
    assign error_o        = (state_q == ERR);
    assign words_loaded_o = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: normal load, empty, oversize, full memory,
// timeout edge, back-to-back bytes and mid-session reset.
module tb_imem_loader;

    logic        clk = 1'b0;
    logic        rst_n, start, rx_valid;
    logic [7:0]  rx_data;
    logic [31:0] cpu_pc;
    logic [31:0] imem_addr, imem_wdata, words_loaded;
    logic        imem_we, cpu_stall, busy, done, error;

    int checks = 0;
    int errors = 0;

    logic [31:0] wa[$];
    logic [31:0] wd[$];

    imem_loader #(.MEM_BYTES(1024), .TIMEOUT_CYCLES(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start),
        .rx_valid_i(rx_valid), .rx_data_i(rx_data), .cpu_pc_i(cpu_pc),
        .imem_addr_o(imem_addr), .imem_we_o(imem_we), .imem_wdata_o(imem_wdata),
        .cpu_stall_o(cpu_stall), .busy_o(busy), .done_o(done), .error_o(error),
        .words_loaded_o(words_loaded)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (imem_we) begin
            wa.push_back(imem_addr);
            wd.push_back(imem_wdata);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic send(input logic [7:0] b);
        pulse(b);
        tick(1);
    endtask

    task automatic send_word(input logic [31:0] w, input bit gap);
        for (int k = 3; k >= 0; k--) begin
            if (gap) send(w[8*k +: 8]);
            else     pulse(w[8*k +: 8]);
        end
    endtask

    task automatic kick();
        wa.delete();
        wd.delete();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    initial begin
        int bad;
        logic [31:0] w;
        rst_n = 1'b0; start = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
        cpu_pc = 32'h0000_1234;
        tick(2);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_stall", {31'd0, cpu_stall}, 32'd0);
        chk("rst_we", {31'd0, imem_we}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_error", {31'd0, error}, 32'd0);
        chk("rst_words", words_loaded, 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_addr", imem_addr, 32'h0000_1234);
        rst_n = 1'b1;
        tick(1);

        // two-word load with idle gaps between bytes
        kick();
        chk("hdr_busy", {31'd0, busy}, 32'd1);
        chk("hdr_stall", {31'd0, cpu_stall}, 32'd1);
        chk("hdr_addr", imem_addr, 32'd0);
        send_word(32'd2, 1'b1);
        send_word(32'hDEAD_BEEF, 1'b1);
        send_word(32'h0123_4567, 1'b1);
        tick(2);
        chk("two_nwr", wa.size(), 32'd2);
        chk("two_a0", wa[0], 32'd0);
        chk("two_d0", wd[0], 32'hDEAD_BEEF);
        chk("two_a1", wa[1], 32'd4);
        chk("two_d1", wd[1], 32'h0123_4567);
        chk("two_done", {31'd0, done}, 32'd1);
        chk("two_words", words_loaded, 32'd2);
        chk("two_stall", {31'd0, cpu_stall}, 32'd0);
        cpu_pc = 32'h0000_0080;
        #1;
        chk("done_addr", imem_addr, 32'h0000_0080);

        // zero-length header; bytes after completion are ignored
        kick();
        send_word(32'd0, 1'b1);
        send(8'h55);
        tick(2);
        chk("zero_done", {31'd0, done}, 32'd1);
        chk("zero_nwr", wa.size(), 32'd0);
        chk("zero_words", words_loaded, 32'd0);

        // oversize length
        kick();
        send_word(32'd257, 1'b1);
        tick(2);
        chk("over_err", {31'd0, error}, 32'd1);
        chk("over_busy", {31'd0, busy}, 32'd0);
        chk("over_nwr", wa.size(), 32'd0);

        // fill the whole memory
        kick();
        chk("restart_err", {31'd0, error}, 32'd0);
        send_word(32'd256, 1'b1);
        for (int i = 0; i < 256; i++) send_word(32'hC0DE_0000 | i, 1'b1);
        tick(2);
        chk("full_nwr", wa.size(), 32'd256);
        bad = 0;
        for (int i = 0; i < wa.size(); i++)
            if (wa[i] !== 32'(4 * i) || wd[i] !== (32'hC0DE_0000 | i)) bad++;
        chk("full_all", bad, 32'd0);
        chk("full_last_a", wa[255], 32'd1020);
        chk("full_last_d", wd[255], 32'hC0DE_00FF);
        chk("full_done", {31'd0, done}, 32'd1);
        chk("full_words", words_loaded, 32'd256);

        // timeout: abort 16 idle cycles after the last byte
        kick();
        send_word(32'd1, 1'b0);
        pulse(8'h11);
        pulse(8'h22);
        tick(15);
        chk("to_15_err", {31'd0, error}, 32'd0);
        chk("to_15_busy", {31'd0, busy}, 32'd1);
        tick(1);
        chk("to_16_err", {31'd0, error}, 32'd1);
        chk("to_nwr", wa.size(), 32'd0);

        // a byte on the expiry cycle keeps the session alive
        kick();
        send_word(32'd1, 1'b0);
        pulse(8'hAA);
        repeat (15) @(posedge clk);
        #1;
        pulse(8'hBB);
        chk("edge_err", {31'd0, error}, 32'd0);
        chk("edge_busy", {31'd0, busy}, 32'd1);
        pulse(8'hCC);
        pulse(8'hDD);
        tick(2);
        chk("edge_nwr", wa.size(), 32'd1);
        chk("edge_d", wd[0], 32'hAABB_CCDD);
        chk("edge_done", {31'd0, done}, 32'd1);

        // back-to-back bytes, including during WRITE cycles
        kick();
        send_word(32'd3, 1'b0);
        send_word(32'h1111_2222, 1'b0);
        send_word(32'h3333_4444, 1'b0);
        send_word(32'h5555_6666, 1'b0);
        tick(2);
        chk("b2b_nwr", wa.size(), 32'd3);
        chk("b2b_d0", wd[0], 32'h1111_2222);
        chk("b2b_d1", wd[1], 32'h3333_4444);
        chk("b2b_d2", wd[2], 32'h5555_6666);
        chk("b2b_a2", wa[2], 32'd8);
        chk("b2b_done", {31'd0, done}, 32'd1);

        // start while busy is ignored; reset mid-session aborts
        kick();
        send_word(32'd2, 1'b1);
        send_word(32'h0BAD_F00D, 1'b1);
        send(8'h12);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        chk("nr_busy", {31'd0, busy}, 32'd1);
        chk("nr_words", words_loaded, 32'd1);
        chk("nr_addr", imem_addr, 32'd4);
        send(8'h34);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_addr", imem_addr, 32'h0000_0080);
        chk("mr_words", words_loaded, 32'd0);
        send(8'h56);
        send(8'h78);
        tick(3);
        chk("mr_nwr", wa.size(), 32'd1);
        chk("mr_d0", wd[0], 32'h0BAD_F00D);
        chk("mr_idle", {30'd0, done, error}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
